// File: rtl/fadd_normalizer.sv
// fadd_normalizer: post-add normalization for the FP32 adder (truncation, valid/ready out).
// Build option: define FADD_NORM_FAST_EN for a single-cycle leading-zero shift instead of 1 bit/cycle.
`default_nettype none

module fadd_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_data,
    output logic                    busy
);

    localparam int MW = FRAC_W + 2;
    localparam int EW = EXP_W + 1;
    localparam int DW = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0]    EXP_ONE = EW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [MW-1:0] mant_q, mant_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [EW-1:0] w_exp_in, w_exp_inc, w_sh_exp;
    logic [MW-1:0] w_sh_mant;

    // Exponent field is zero when the hidden bit is clear (denormal) and saturates at all-ones.
    function automatic logic [DW-1:0] pack(input logic s, input logic [EW-1:0] e,
                                           input logic [MW-1:0] m);
        logic [EXP_W-1:0] fld;
        if (!m[FRAC_W])
            fld = '0;
        else if (e > {1'b0, EXP_MAX})
            fld = EXP_MAX;
        else
            fld = e[EXP_W-1:0];
        return {s, fld, m[FRAC_W-1:0]};
    endfunction

    assign w_exp_in  = {1'b0, in_exp};
    assign w_exp_inc = w_exp_in + EXP_ONE;
    assign w_sh_mant = mant_q << 1;
    assign w_sh_exp  = exp_q - EXP_ONE;

`ifdef FADD_NORM_FAST_EN
    logic [EW-1:0] w_lzc, w_lim, w_shamt;
    logic [MW-1:0] w_fast_mant;
    logic [EW-1:0] w_fast_exp;

    always_comb begin
        w_lzc = EW'(FRAC_W);
        for (int i = 0; i <= FRAC_W; i++) begin
            if (in_mant[i])
                w_lzc = EW'(FRAC_W - i);
        end
        w_lim       = (w_exp_in > EXP_ONE) ? (w_exp_in - EXP_ONE) : '0;
        w_shamt     = (w_lzc < w_lim) ? w_lzc : w_lim;
        w_fast_mant = in_mant << w_shamt;
        w_fast_exp  = w_exp_in - w_shamt;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d      = in_sign;
                    exp_d       = w_exp_in;
                    mant_d      = in_mant;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    if (in_exp == EXP_MAX) begin
                        out_data_d = {in_sign, EXP_MAX, in_mant[FRAC_W-1:0]};
                    end else if (in_mant == '0) begin
                        out_data_d = '0;
                    end else if (in_mant[MW-1]) begin
                        if (w_exp_inc[EXP_W-1:0] == EXP_MAX)
                            out_data_d = {in_sign, EXP_MAX, {FRAC_W{1'b0}}};
                        else
                            out_data_d = pack(in_sign, w_exp_inc, in_mant >> 1);
                    end else if (in_mant[FRAC_W]) begin
                        out_data_d = pack(in_sign, w_exp_in, in_mant);
                    end else begin
`ifdef FADD_NORM_FAST_EN
                        out_data_d = pack(in_sign, w_fast_exp, w_fast_mant);
`else
                        // Nothing to shift when the exponent is already at its floor.
                        if (w_exp_in <= EXP_ONE) begin
                            out_data_d = pack(in_sign, w_exp_in, in_mant);
                        end else begin
                            state_d     = S_SHIFT;
                            out_valid_d = 1'b0;
                        end
`endif
                    end
                end
            end
            S_SHIFT: begin
                mant_d = w_sh_mant;
                exp_d  = w_sh_exp;
                if (w_sh_mant[FRAC_W] || (w_sh_exp <= EXP_ONE)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = pack(sign_q, w_sh_exp, w_sh_mant);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fadd_normalizer.sv
// tb_fadd_normalizer: directed vectors with hand-computed results for fadd_normalizer.
`default_nettype none

module tb_fadd_normalizer;

`ifdef FADD_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fadd_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Accept one vector, measure cycles from accept edge to out_valid, return data.
    task automatic run(input logic s, input logic [7:0] e, input logic [24:0] m,
                       output int lat, output logic [31:0] data);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        data = out_data;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] d;

        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 8'h7F, 25'h1000000, lat, d);
        chk("carry_data", d, 32'h40000000);
        chk("carry_lat", lat, 1);
        drain("carry");

        run(1'b0, 8'h80, 25'h0000001, lat, d);
        chk("lz23_data", d, 32'h34800000);
        chk("lz23_lat", lat, FAST ? 1 : 24);
        drain("lz23");

        run(1'b1, 8'h85, 25'h0, lat, d);
        chk("zero_data", d, 32'h00000000);
        chk("zero_lat", lat, 1);
        drain("zero");

        run(1'b0, 8'hFE, 25'h1800000, lat, d);
        chk("ovf_data", d, 32'h7F800000);
        chk("ovf_lat", lat, 1);
        drain("ovf");

        run(1'b0, 8'h03, 25'h0000100, lat, d);
        chk("denorm_data", d, 32'h00000400);
        chk("denorm_lat", lat, FAST ? 1 : 3);
        drain("denorm");

        run(1'b1, 8'hFF, 25'h0000123, lat, d);
        chk("pass_data", d, 32'hFF800123);
        chk("pass_lat", lat, 1);
        drain("pass");

        run(1'b1, 8'h81, 25'h0C00000, lat, d);
        chk("norm_data", d, 32'hC0C00000);
        chk("norm_lat", lat, 1);
        drain("norm");

        // Consumer stalls: result and handshake must hold steady.
        run(1'b1, 8'h85, 25'h0200000, lat, d);
        chk("lz2_data", d, 32'hC1800000);
        chk("lz2_lat", lat, FAST ? 1 : 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_data", out_data, 32'hC1800000);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        drain("hold");

        // Asynchronous reset in the middle of a long normalization.
        in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 8'h03, 25'h0000100, lat, d);
        chk("post_data", d, 32'h00000400);
        chk("post_lat", lat, FAST ? 1 : 3);
        drain("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
